// File: rtl/em_stream_driver.sv
// em_stream_driver: sequences spin, weight rows and energy between host, weight SRAM and energy monitor.
// Define EM_DRV_PREFETCH_EN to replace the single row buffer with a 2-entry prefetching FIFO.
module em_stream_driver #(
  parameter int NUM_SPIN = 256,
  parameter int NUM_ROWS = 256,
  parameter int ROW_W    = 256,
  parameter int ENERGY_W = 32,
  parameter int AW       = $clog2(NUM_ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [NUM_SPIN-1:0] cmd_spin_i,
  output logic                wmem_req_o,
  output logic [AW-1:0]       wmem_addr_o,
  input  logic [ROW_W-1:0]    wmem_rdata_i,
  output logic                spin_valid_o,
  input  logic                spin_ready_i,
  output logic [NUM_SPIN-1:0] spin_o,
  output logic                weight_valid_o,
  input  logic                weight_ready_i,
  output logic [ROW_W-1:0]    weight_o,
  input  logic                energy_valid_i,
  output logic                energy_ready_o,
  input  logic [ENERGY_W-1:0] energy_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ENERGY_W-1:0] result_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPIN   = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT_E = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  localparam logic [AW:0] C_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] C_ROWS = (AW+1)'(NUM_ROWS);
  localparam logic [AW:0] C_LAST = C_ROWS - C_ONE;

  state_t              r_state;
  state_t              w_state_run;
  state_t              w_state_nxt;
  logic [NUM_SPIN-1:0] r_spin;
  logic [ENERGY_W-1:0] r_result;
  logic [AW:0]         r_fetch_cnt;
  logic [AW:0]         r_send_cnt;
  logic                r_rd_pend;
  logic                w_req;
  logic                w_buf_valid;
  logic [ROW_W-1:0]    w_buf_data;
  logic                w_cmd_hs;
  logic                w_weight_hs;
  logic                w_energy_hs;
  logic                w_rows_left;

  assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign w_weight_hs = weight_valid_o & weight_ready_i;
  assign w_energy_hs = energy_valid_i & energy_ready_o;
  assign w_rows_left = (r_fetch_cnt != C_ROWS);

  assign wmem_req_o     = w_req;
  assign wmem_addr_o    = r_fetch_cnt[AW-1:0];
  assign spin_o         = r_spin;
  assign result_o       = r_result;
  assign weight_valid_o = w_buf_valid;
  assign weight_o       = w_buf_data;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; en_i low forces IDLE on the next edge
  always_comb begin
    w_state_run    = r_state;
    cmd_ready_o    = 1'b0;
    spin_valid_o   = 1'b0;
    energy_ready_o = 1'b0;
    result_valid_o = 1'b0;
    busy_o         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy_o      = 1'b0;
        cmd_ready_o = en_i;
        if (cmd_valid_i) begin
          w_state_run = ST_SPIN;
        end else begin
          w_state_run = ST_IDLE;
        end
      end
      ST_SPIN: begin
        spin_valid_o = 1'b1;
        if (spin_ready_i) begin
          w_state_run = ST_STREAM;
        end else begin
          w_state_run = ST_SPIN;
        end
      end
      ST_STREAM: begin
        if (w_weight_hs && (r_send_cnt == C_LAST)) begin
          w_state_run = ST_WAIT_E;
        end else begin
          w_state_run = ST_STREAM;
        end
      end
      ST_WAIT_E: begin
        energy_ready_o = 1'b1;
        if (energy_valid_i) begin
          w_state_run = ST_RESULT;
        end else begin
          w_state_run = ST_WAIT_E;
        end
      end
      ST_RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          w_state_run = ST_IDLE;
        end else begin
          w_state_run = ST_RESULT;
        end
      end
      default: begin
        busy_o      = 1'b0;
        w_state_run = ST_IDLE;
      end
    endcase
    w_state_nxt = en_i ? w_state_run : ST_IDLE;
  end

  // Spin vector and energy result capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spin   <= '0;
      r_result <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_spin <= cmd_spin_i;
      end
      if (w_energy_hs) begin
        r_result <= energy_i;
      end
    end
  end

  // Fetch and send counters, restarted per command and on disable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_cnt <= '0;
      r_send_cnt  <= '0;
    end else if (!en_i || w_cmd_hs) begin
      r_fetch_cnt <= '0;
      r_send_cnt  <= '0;
    end else begin
      if (w_req) begin
        r_fetch_cnt <= r_fetch_cnt + C_ONE;
      end
      if (w_weight_hs) begin
        r_send_cnt <= r_send_cnt + C_ONE;
      end
    end
  end

  // Read-outstanding flag; w_req is already gated by en_i so a disable drops it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_req;
    end
  end

`ifdef EM_DRV_PREFETCH_EN
  logic [ROW_W-1:0] r_fifo [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic [1:0]       w_level;

  // Counting the pop in the same cycle keeps rows flowing back to back
  assign w_level     = r_cnt + {1'b0, r_rd_pend} - {1'b0, w_weight_hs};
  assign w_req       = en_i & (r_state == ST_STREAM) & w_rows_left & (w_level < 2'd2);
  assign w_buf_valid = (r_cnt != 2'd0);
  assign w_buf_data  = r_fifo[r_rd_ptr];

  // Two-entry row FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
    end else if (!en_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (r_rd_pend) begin
        r_fifo[r_wr_ptr] <= wmem_rdata_i;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_weight_hs) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, r_rd_pend} - {1'b0, w_weight_hs};
    end
  end
`else
  logic [ROW_W-1:0] r_buf;
  logic             r_buf_full;

  assign w_req       = en_i & (r_state == ST_STREAM) & w_rows_left & ~r_buf_full & ~r_rd_pend;
  assign w_buf_valid = r_buf_full;
  assign w_buf_data  = r_buf;

  // Single-entry row buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (!en_i) begin
      r_buf_full <= 1'b0;
    end else if (r_rd_pend) begin
      r_buf      <= wmem_rdata_i;
      r_buf_full <= 1'b1;
    end else if (w_weight_hs) begin
      r_buf_full <= 1'b0;
    end
  end
`endif

endmodule
